// File: rtl/dut_clk_sequencer.sv
// DUT clock/reset sequencer: holds the DUT in reset for 2^DELAY_BIT cycles, then
// produces a divided DUT clock that can free-run, single-step or halt cleanly.
`timescale 1ns/1ps
module dut_clk_sequencer #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 6000,
  parameter int DELAY_BIT   = 15
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_req,
  input  logic             reset_req,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             clk_dut,
  output logic             rst_dut,
  output logic             step_done,
  output logic             load_err,
  output logic [1:0]       state,
  output logic [15:0]      cycle_count
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  localparam logic [DELAY_BIT-1:0] DELAY_LAST = {DELAY_BIT{1'b1}};
  localparam logic [DIV_W-1:0]     DIV_RESET  = DIV_W'(DEFAULT_DIV);

  state_t             state_r, state_s;
  logic [DELAY_BIT-1:0] delay_cnt_r, delay_cnt_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [DIV_W-1:0]   div_cnt_r, div_cnt_s;
  logic               clk_dut_r, clk_dut_s;
  logic               rst_dut_r, rst_dut_s;
  logic               step_done_r, step_done_s;
  logic               load_err_r, load_err_s;
  logic [15:0]        cycle_count_r, cycle_count_s;
  logic               tick_s;

  assign tick_s = (div_cnt_r == div_r);

  // Next-state and next-output computation; reset_req overrides everything.
  always_comb begin
    state_s       = state_r;
    delay_cnt_s   = delay_cnt_r;
    div_cnt_s     = div_cnt_r;
    clk_dut_s     = clk_dut_r;
    step_done_s   = 1'b0;
    cycle_count_s = cycle_count_r;
    if (reset_req) begin
      state_s       = S_HOLD;
      delay_cnt_s   = {DELAY_BIT{1'b0}};
      div_cnt_s     = {DIV_W{1'b0}};
      clk_dut_s     = 1'b0;
      cycle_count_s = 16'd0;
    end else begin
      case (state_r)
        S_HOLD: begin
          clk_dut_s = 1'b0;
          div_cnt_s = {DIV_W{1'b0}};
          if (delay_cnt_r == DELAY_LAST) begin
            state_s     = S_HALT;
            delay_cnt_s = {DELAY_BIT{1'b0}};
          end else begin
            delay_cnt_s = delay_cnt_r + 1'b1;
          end
        end
        S_HALT: begin
          clk_dut_s = 1'b0;
          div_cnt_s = {DIV_W{1'b0}};
          if (run) begin
            state_s = S_RUN;
          end else if (step_req) begin
            state_s = S_STEP;
          end else begin
            state_s = S_HALT;
          end
        end
        S_RUN: begin
          // A high phase in progress is always allowed to finish before halting.
          if (!run && !clk_dut_r) begin
            state_s   = S_HALT;
            div_cnt_s = {DIV_W{1'b0}};
          end else if (tick_s) begin
            clk_dut_s = ~clk_dut_r;
            div_cnt_s = {DIV_W{1'b0}};
            if (clk_dut_r && !run) begin
              state_s = S_HALT;
            end else begin
              state_s = S_RUN;
            end
          end else begin
            div_cnt_s = div_cnt_r + 1'b1;
          end
        end
        S_STEP: begin
          if (tick_s) begin
            clk_dut_s = ~clk_dut_r;
            div_cnt_s = {DIV_W{1'b0}};
            if (clk_dut_r) begin
              state_s     = S_HALT;
              step_done_s = 1'b1;
            end else begin
              state_s = S_STEP;
            end
          end else begin
            div_cnt_s = div_cnt_r + 1'b1;
          end
        end
        default: begin
          state_s     = S_HOLD;
          delay_cnt_s = {DELAY_BIT{1'b0}};
          div_cnt_s   = {DIV_W{1'b0}};
          clk_dut_s   = 1'b0;
        end
      endcase
      if (clk_dut_s && !clk_dut_r) begin
        cycle_count_s = cycle_count_r + 16'd1;
      end else begin
        cycle_count_s = cycle_count_r;
      end
    end
  end

  // Divider load arbitration: only a clean HALT cycle may change the divider.
  always_comb begin
    load_err_s = div_load && (reset_req || (state_r != S_HALT));
    if (div_load && !load_err_s) begin
      div_s = div_value;
    end else begin
      div_s = div_r;
    end
    rst_dut_s = (state_s == S_HOLD);
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_HOLD;
      delay_cnt_r   <= {DELAY_BIT{1'b0}};
      div_r         <= DIV_RESET;
      div_cnt_r     <= {DIV_W{1'b0}};
      clk_dut_r     <= 1'b0;
      rst_dut_r     <= 1'b1;
      step_done_r   <= 1'b0;
      load_err_r    <= 1'b0;
      cycle_count_r <= 16'd0;
    end else begin
      state_r       <= state_s;
      delay_cnt_r   <= delay_cnt_s;
      div_r         <= div_s;
      div_cnt_r     <= div_cnt_s;
      clk_dut_r     <= clk_dut_s;
      rst_dut_r     <= rst_dut_s;
      step_done_r   <= step_done_s;
      load_err_r    <= load_err_s;
      cycle_count_r <= cycle_count_s;
    end
  end

  assign clk_dut     = clk_dut_r;
  assign rst_dut     = rst_dut_r;
  assign step_done   = step_done_r;
  assign load_err    = load_err_r;
  assign state       = state_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_dut_clk_sequencer.sv
// Directed self-checking bench for dut_clk_sequencer (DELAY_BIT=3, DEFAULT_DIV=2).
`timescale 1ns/1ps
module tb_dut_clk_sequencer;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic        reset_req = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_value = 16'd0;
  logic        clk_dut, rst_dut, step_done, load_err;
  logic [1:0]  state;
  logic [15:0] cycle_count;
  logic [5:0]  obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dut_clk_sequencer #(.DIV_W(16), .DEFAULT_DIV(2), .DELAY_BIT(3)) dut (
    .CLK(CLK), .rst_n(rst_n), .run(run), .step_req(step_req),
    .reset_req(reset_req), .div_load(div_load), .div_value(div_value),
    .clk_dut(clk_dut), .rst_dut(rst_dut), .step_done(step_done),
    .load_err(load_err), .state(state), .cycle_count(cycle_count)
  );

  // {state, rst_dut, clk_dut, step_done, load_err}
  assign obs = {state, rst_dut, clk_dut, step_done, load_err};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    #12;
    n_cmp++;
    if (obs !== 6'b00_1_0_0_0 || cycle_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state got %b/%h want 001000/0000", obs, cycle_count);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 8) ? 6'b00_1_0_0_0 : 6'b01_0_0_0_0;
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL reset_hold edge=%0d got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_run();
    logic        exp_clk;
    logic [15:0] exp_cc;
    run = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      tick();
      exp_clk = (k < 4) ? 1'b0 : ((((k - 4) / 3) % 2) == 0);
      exp_cc  = (k < 4) ? 16'd0 : 16'((k - 4) / 6 + 1);
      n_cmp++;
      if (obs !== {2'd2, 1'b0, exp_clk, 1'b0, 1'b0} || cycle_count !== exp_cc) begin
        n_bad++;
        $display("FAIL run_wave k=%0d got %b/%h want %b/%h", k, obs,
                 cycle_count, {2'd2, 1'b0, exp_clk, 1'b0, 1'b0}, exp_cc);
      end
    end
    run = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 6'b10_0_1_0_0) begin
      n_bad++;
      $display("FAIL run_drop_high got %b want 100100", obs);
    end
    tick();
    n_cmp++;
    if (obs !== 6'b01_0_0_0_0 || cycle_count !== 16'd5) begin
      n_bad++;
      $display("FAIL run_drop_halt got %b/%h want 010000/0005", obs, cycle_count);
    end
  endtask

  task automatic test_run_stop_low();
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 6'b01_0_0_0_0 || cycle_count !== 16'd5) begin
      n_bad++;
      $display("FAIL run_stop_low got %b/%h want 010000/0005", obs, cycle_count);
    end
  endtask

  task automatic test_step_div0();
    logic [5:0] exp_seq [4];
    exp_seq[0] = 6'b11_0_0_0_0;
    exp_seq[1] = 6'b11_0_1_0_0;
    exp_seq[2] = 6'b01_0_0_1_0;
    exp_seq[3] = 6'b01_0_0_0_0;
    div_load = 1'b1; div_value = 16'd0;
    tick();
    div_load = 1'b0;
    n_cmp++;
    if (obs !== 6'b01_0_0_0_0) begin
      n_bad++;
      $display("FAIL halt_load got %b want 010000", obs);
    end
    step_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      step_req = 1'b0;
      n_cmp++;
      if (obs !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL step_seq i=%0d got %b want %b", i, obs, exp_seq[i]);
      end
    end
    n_cmp++;
    if (cycle_count !== 16'd6) begin
      n_bad++;
      $display("FAIL step_count got %h want 0006", cycle_count);
    end
  endtask

  task automatic test_reject_and_reset();
    logic       exp_clk;
    logic [5:0] exp;
    div_load = 1'b1; div_value = 16'd2;
    tick();
    div_load = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) begin
        div_load = 1'b1; div_value = 16'd7; step_req = 1'b1;
      end
      tick();
      div_load = 1'b0; step_req = 1'b0;
      exp_clk = (k < 4) ? 1'b0 : ((((k - 4) / 3) % 2) == 0);
      exp = {2'd2, 1'b0, exp_clk, 1'b0, (k == 5)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL run_reject k=%0d got %b want %b", k, obs, exp);
      end
    end
    reset_req = 1'b1; div_load = 1'b1; div_value = 16'd9;
    tick();
    reset_req = 1'b0; div_load = 1'b0; run = 1'b0;
    n_cmp++;
    if (obs !== 6'b00_1_0_0_1 || cycle_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_req got %b/%h want 001001/0000", obs, cycle_count);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 8) ? 6'b00_1_0_0_0 : 6'b01_0_0_0_0;
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL rehold edge=%0d got %b want %b", i, obs, exp);
      end
    end
    // Divider must still be 2: rejected loads never took effect.
    run = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) run = 1'b0;
      exp_clk = (k >= 4 && k <= 6);
      exp = {(k == 7) ? 2'd1 : 2'd2, 1'b0, exp_clk, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL div_kept k=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cc [5];
    exp_cc[0] = 16'hFFFE; exp_cc[1] = 16'hFFFE; exp_cc[2] = 16'hFFFF;
    exp_cc[3] = 16'hFFFF; exp_cc[4] = 16'h0000;
    div_load = 1'b1; div_value = 16'd0;
    tick();
    div_load = 1'b0;
    run = 1'b1;
    tick();
    // Preload the counter close to the top instead of spending 64K DUT periods.
    force dut.cycle_count_r = 16'hFFFD;
    #1;
    release dut.cycle_count_r;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (cycle_count !== exp_cc[k-1] || clk_dut !== k[0]) begin
        n_bad++;
        $display("FAIL wrap k=%0d got %h/%b want %h/%b", k, cycle_count,
                 clk_dut, exp_cc[k-1], k[0]);
      end
    end
    run = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 6'b01_0_0_0_0 || cycle_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_halt got %b/%h want 010000/0000", obs, cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_run_stop_low();
    test_step_div0();
    test_reject_and_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
